gcd_stein_stream: RTL and testbench



---
 rtl/gcd_stein_stream_pkg.sv | 21 ++
 rtl/gcd_stein_stream_if.sv | 25 ++
 rtl/gcd_stein_stream_fifo.sv | 50 +++++
 rtl/gcd_stein_stream.sv | 144 ++++++++++++++
 tb/tb_gcd_stein_stream.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gcd_stein_stream_pkg.sv
// rtl/gcd_stein_stream_pkg.sv - shared state encoding and constant helpers for the Stein GCD engine
package gcd_stein_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Elaboration-time ceiling log2; returns 0 for v <= 1.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_stein_stream_if.sv
// rtl/gcd_stein_stream_if.sv - request/result handshake bundle for the streaming GCD engine
interface gcd_stein_stream_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out0;
    logic [CW-1:0]    out1;
    logic             busy;

    modport master (
        output in_valid, in0, in1, out_ready,
        input  in_ready, out_valid, out0, out1, busy
    );

    modport slave (
        input  in_valid, in0, in1, out_ready,
        output in_ready, out_valid, out0, out1, busy
    );
endinterface

// File: rtl/gcd_stein_stream_fifo.sv
// rtl/gcd_stein_stream_fifo.sv - synchronous request FIFO (gcd_fifo) with wrap-bit pointers
module gcd_fifo
    import gcd_stein_stream_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = clog2_f(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    // The extra MSB separates full (MSBs differ) from empty (pointers equal).
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gcd_stein_stream.sv
// rtl/gcd_stein_stream.sv - streaming binary (Stein) GCD engine with request FIFO and duplicate suppression
module gcd_stein_stream
    import gcd_stein_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DEDUP = 1,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    gcd_stein_stream_if.slave  bus
);
    localparam int KW = clog2_f(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [PW-1:0]    last_q, last_d;
    logic             last_vld_q, last_vld_d;

    logic [PW-1:0]    pair;
    logic [PW-1:0]    fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             accept, dup, push, pop;
    logic             x_zero, y_zero;

    // A repeat of the last accepted pair is acknowledged but never queued.
    always_comb begin
        pair       = {bus.in0, bus.in1};
        accept     = bus.in_valid && !fifo_full;
        dup        = (DEDUP != 0) && last_vld_q && (pair == last_q);
        push       = accept && !dup;
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        last_d     = accept ? pair : last_q;
        last_vld_d = last_vld_q || accept;
    end

    gcd_fifo #(
        .DW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (pair),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        x_zero  = (x_q == '0);
        y_zero  = (y_q == '0);
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (x_zero || y_zero)        state_d = ST_DONE;
                else if (x_q[0] || y_q[0])   state_d = ST_REDUCE;
            end
            ST_REDUCE: if (x_zero || y_zero) state_d = ST_DONE;
            ST_DONE:   if (bus.out_ready)    state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = !fifo_full;
        bus.out_valid = (state_q == ST_DONE);
        bus.busy      = (state_q != ST_IDLE);
        bus.out0      = res_q;
        bus.out1      = cnt_q;
    end

    // Datapath: common factors of two are stripped in SHIFT and restored via k on exit.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    x_d   = fifo_rdata[PW-1:WIDTH];
                    y_d   = fifo_rdata[WIDTH-1:0];
                    k_d   = '0;
                    cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_inc;
                if (x_zero || y_zero) begin
                    res_d = x_q | y_q;
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
                end
            end
            ST_REDUCE: begin
                cnt_d = cnt_inc;
                if (x_zero)               res_d = y_q << k_q;
                else if (y_zero)          res_d = x_q << k_q;
                else if (!x_q[0])         x_d   = x_q >> 1;
                else if (!y_q[0])         y_d   = y_q >> 1;
                else if (x_q >= y_q)      x_d   = (x_q - y_q) >> 1;
                else                      y_d   = (y_q - x_q) >> 1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end

endmodule

// File: tb/tb_gcd_stein_stream.sv
// tb/tb_gcd_stein_stream.sv - directed bench for an 8-bit dedup instance and a 16-bit non-dedup CW=4 instance
module tb_gcd_stein_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gcd_stein_stream_if #(.WIDTH(8),  .CW(8)) b8 ();
    gcd_stein_stream_if #(.WIDTH(16), .CW(4)) b16 ();

    gcd_stein_stream #(.WIDTH(8),  .DEPTH(4), .DEDUP(1), .CW(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));
    gcd_stein_stream #(.WIDTH(16), .DEPTH(4), .DEDUP(0), .CW(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        int          c;
    } vec_t;

    vec_t tbl [7];

    function automatic logic ov(input int w);
        return (w == 0) ? b8.out_valid : b16.out_valid;
    endfunction
    function automatic logic ir(input int w);
        return (w == 0) ? b8.in_ready : b16.in_ready;
    endfunction
    function automatic logic [15:0] o0(input int w);
        return (w == 0) ? {8'd0, b8.out0} : b16.out0;
    endfunction
    function automatic logic [7:0] o1(input int w);
        return (w == 0) ? b8.out1 : {4'd0, b16.out1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int w, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!ir(w) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_in_ready_timeout", 32'(ir(w)), 32'd1);
        if (w == 0) begin
            b8.in_valid = 1'b1; b8.in0 = a[7:0]; b8.in1 = b[7:0];
        end else begin
            b16.in_valid = 1'b1; b16.in0 = a; b16.in1 = b;
        end
        tick();
        b8.in_valid  = 1'b0;
        b16.in_valid = 1'b0;
    endtask

    task automatic recv(input int w, input logic [15:0] eg, input int ec, input string nm);
        int n;
        n = 0;
        b8.out_ready  = 1'b1;
        b16.out_ready = 1'b1;
        while (!ov(w) && n < 300) begin
            tick();
            n++;
        end
        if (!ov(w)) begin
            chk({nm, "_timeout"}, 32'(ov(w)), 32'd1);
        end else begin
            chk({nm, "_gcd"}, 32'(o0(w)), 32'(eg));
            chk({nm, "_cnt"}, 32'(o1(w)), 32'(ec));
            tick();
        end
    endtask

    task automatic quiet(input int w, input int cycles, input string nm);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (ov(w)) seen++;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [15:0] h0;
        logic [7:0]  h1;

        tbl[0] = '{16'd65535, 16'd65535, 16'd65535, 3};
        tbl[1] = '{16'd40000, 16'd30000, 16'd10000, 10};
        tbl[2] = '{16'd255,   16'd256,   16'd1,     15};
        tbl[3] = '{16'd48,    16'd18,    16'd6,     8};
        tbl[4] = '{16'd0,     16'd0,     16'd0,     1};
        tbl[5] = '{16'd7,     16'd0,     16'd7,     1};
        tbl[6] = '{16'd1,     16'd1,     16'd1,     3};

        b8.in_valid = 0;  b8.in0 = 0;  b8.in1 = 0;  b8.out_ready = 0;
        b16.in_valid = 0; b16.in0 = 0; b16.in1 = 0; b16.out_ready = 0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_out0",      32'(b8.out0),      32'd0);
        chk("rst_out1",      32'(b8.out1),      32'd0);
        chk("rst_busy",      32'(b8.busy),      32'd0);
        chk("rst_in_ready",  32'(b8.in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // Basic request.
        b8.out_ready = 1'b1;
        send(0, 12, 18);
        recv(0, 6, 6, "basic_12_18");
        chk("basic_busy_after", 32'(b8.busy), 32'd0);

        // Zero operand latency: out_valid visible two edges after the accept edge.
        send(0, 0, 5);
        chk("lat_t1_valid", 32'(b8.out_valid), 32'd0);
        tick();
        chk("lat_t2_valid", 32'(b8.out_valid), 32'd0);
        tick();
        chk("lat_t3_valid", 32'(b8.out_valid), 32'd1);
        chk("lat_out0",     32'(b8.out0),      32'd5);
        chk("lat_out1",     32'(b8.out1),      32'd1);
        tick();
        send(0, 0, 0);
        recv(0, 0, 1, "zero_zero");

        // Duplicate suppression.
        send(0, 12, 18);
        send(0, 12, 18);
        send(0, 9, 6);
        recv(0, 6, 6, "dedup_first");
        recv(0, 3, 5, "dedup_second");
        quiet(0, 30, "dedup_no_third");

        // Backpressure: first request popped, four fill the FIFO.
        b8.out_ready = 1'b0;
        send(0, 12, 18);
        send(0, 9, 6);
        send(0, 20, 30);
        send(0, 7, 21);
        send(0, 16, 24);
        chk("bp_in_ready_full", 32'(b8.in_ready), 32'd0);
        b8.in_valid = 1'b1; b8.in0 = 8'd1; b8.in1 = 8'd1;
        repeat (2) begin
            tick();
            chk("bp_full_stays", 32'(b8.in_ready), 32'd0);
        end
        b8.in_valid = 1'b0;
        for (int n = 0; n < 40 && !b8.out_valid; n++) tick();
        h0 = o0(0);
        h1 = o1(0);
        repeat (4) begin
            tick();
            chk("bp_hold_valid", 32'(b8.out_valid), 32'd1);
            chk("bp_hold_out0",  32'(o0(0)), 32'(h0));
            chk("bp_hold_out1",  32'(o1(0)), 32'(h1));
        end
        recv(0, 6,  6, "bp_r0");
        recv(0, 3,  5, "bp_r1");
        recv(0, 10, 6, "bp_r2");
        recv(0, 7,  4, "bp_r3");
        recv(0, 8,  8, "bp_r4");
        quiet(0, 40, "bp_no_extra");

        // Reset while in REDUCE with two requests queued.
        send(0, 255, 1);
        send(0, 12, 18);
        send(0, 9, 6);
        tick();
        chk("mid_busy_before", 32'(b8.busy),      32'd1);
        chk("mid_valid_before", 32'(b8.out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",    32'(b8.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(b8.in_ready),  32'd1);
        chk("mid_rst_busy",     32'(b8.busy),      32'd0);
        chk("mid_rst_out0",     32'(b8.out0),      32'd0);
        quiet(0, 40, "mid_no_stale");
        send(0, 9, 6);
        recv(0, 3, 5, "mid_last_pair_cleared");

        // 16-bit, DEDUP=0: repeats each produce a result.
        b16.out_ready = 1'b1;
        send(1, 12, 18);
        send(1, 12, 18);
        send(1, 9, 6);
        recv(1, 6, 6, "nodup_r0");
        recv(1, 6, 6, "nodup_r1");
        recv(1, 3, 5, "nodup_r2");
        quiet(1, 20, "nodup_no_extra");

        for (int i = 0; i < 7; i++) begin
            send(1, tbl[i].a, tbl[i].b);
            recv(1, tbl[i].g, tbl[i].c, $sformatf("tbl%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
